// File: rtl/vnu_3.sv
// vnu_3: pipelined degree-3 variable-node unit.
//
// Decodes the channel message and three c2v messages from the 4-bit index code
// into signed odd integers, sums them, forms the extrinsic v2c message for each
// edge (total minus that edge's own c2v), requantises and re-encodes it.
// Three registered stages give a fixed three-cycle latency at one message per cycle.
//
// Ports:
//   sys_clk                      clock, rising edge
//   rstn                         asynchronous active-low reset
//   in_valid                     qualifies ch_msg / ch_to_var_* this cycle
//   ch_msg                       channel message (index code)
//   ch_to_var_0..2               c2v messages (index code)
//   var_to_ch_0..2               extrinsic v2c messages (index code)
//   out_valid                    qualifies var_to_ch_* this cycle
//   msg_cnt                      count of out_valid pulses since reset, wraps
//   hard_decision                sign of the total (1 when T >= 0);
//                                present only when VNU_DECISION_EN is defined
//
// Optional feature macro: VNU_DECISION_EN.

module vnu_3 #(
    parameter int unsigned VN_DEGREE = 3,
    parameter int unsigned QUAN_SIZE = 4,
    parameter int unsigned MAG_SIZE  = 3,
    parameter int unsigned SUM_WIDTH = 8,
    parameter int unsigned RQ_SHIFT  = 1
) (
    input  logic                 sys_clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    input  logic [QUAN_SIZE-1:0] ch_msg,
    input  logic [QUAN_SIZE-1:0] ch_to_var_0,
    input  logic [QUAN_SIZE-1:0] ch_to_var_1,
    input  logic [QUAN_SIZE-1:0] ch_to_var_2,
    output logic [QUAN_SIZE-1:0] var_to_ch_0,
    output logic [QUAN_SIZE-1:0] var_to_ch_1,
    output logic [QUAN_SIZE-1:0] var_to_ch_2,
    output logic                 out_valid,
    output logic [15:0]          msg_cnt
`ifdef VNU_DECISION_EN
    ,
    output logic                 hard_decision
`endif
);

    localparam int unsigned MagMax = (1 << MAG_SIZE) - 1;

    typedef logic signed [SUM_WIDTH-1:0] sval_t;

    // Index code -> signed odd value: low bits are the magnitude when the sign
    // bit is set and its complement otherwise.
    function automatic sval_t decode(input logic [QUAN_SIZE-1:0] code);
        logic             s;
        logic [MAG_SIZE-1:0] m;
        sval_t            odd;
        s   = code[QUAN_SIZE-1];
        m   = ~(code[MAG_SIZE-1:0] ^ {MAG_SIZE{s}});
        odd = SUM_WIDTH'({m, 1'b1});
        return s ? odd : -odd;
    endfunction

    // Signed odd extrinsic -> saturated index code.
    function automatic logic [QUAN_SIZE-1:0] encode(input sval_t e);
        logic [SUM_WIDTH-1:0] abs_e;
        logic [SUM_WIDTH-1:0] q;
        logic [MAG_SIZE-1:0]  mag;
        abs_e = e[SUM_WIDTH-1] ? -e : e;
        q     = ((abs_e - SUM_WIDTH'(1)) >> 1) >> RQ_SHIFT;
        if (q > SUM_WIDTH'(MagMax)) begin
            mag = MAG_SIZE'(MagMax);
        end else begin
            mag = q[MAG_SIZE-1:0];
        end
        return (e > 0) ? {1'b1, mag} : {1'b0, ~mag};
    endfunction

    logic [QUAN_SIZE-1:0] c2v_in [VN_DEGREE];
    assign c2v_in[0] = ch_to_var_0;
    assign c2v_in[1] = ch_to_var_1;
    assign c2v_in[2] = ch_to_var_2;

    // Stage 1: decoded inputs.
    logic  s1_valid_q;
    sval_t s1_ch_q;
    sval_t s1_c_q [VN_DEGREE];
    // Stage 2: total plus the c2v values needed for the extrinsic subtraction.
    logic  s2_valid_q;
    sval_t s2_t_q;
    sval_t s2_c_q [VN_DEGREE];
    // Stage 3: registered outputs.
    logic                 s3_valid_q;
    logic [QUAN_SIZE-1:0] v2c_q [VN_DEGREE];
    logic [15:0]          msg_cnt_q;
    sval_t                s2_t_d;

    always_comb begin
        s2_t_d = s1_ch_q;
        for (int i = 0; i < VN_DEGREE; i++) begin
            s2_t_d = s2_t_d + s1_c_q[i];
        end
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
            s1_ch_q    <= '0;
            s2_t_q     <= '0;
            msg_cnt_q  <= '0;
            for (int i = 0; i < VN_DEGREE; i++) begin
                s1_c_q[i] <= '0;
                s2_c_q[i] <= '0;
                v2c_q[i]  <= '0;
            end
        end else begin
            s1_valid_q <= in_valid;
            s2_valid_q <= s1_valid_q;
            s3_valid_q <= s2_valid_q;
            msg_cnt_q  <= msg_cnt_q + {15'd0, s3_valid_q};
            if (in_valid) begin
                s1_ch_q <= decode(ch_msg);
                for (int i = 0; i < VN_DEGREE; i++) begin
                    s1_c_q[i] <= decode(c2v_in[i]);
                end
            end
            if (s1_valid_q) begin
                s2_t_q <= s2_t_d;
                for (int i = 0; i < VN_DEGREE; i++) begin
                    s2_c_q[i] <= s1_c_q[i];
                end
            end
            if (s2_valid_q) begin
                for (int i = 0; i < VN_DEGREE; i++) begin
                    v2c_q[i] <= encode(s2_t_q - s2_c_q[i]);
                end
            end
        end
    end

`ifdef VNU_DECISION_EN
    logic hd_q;

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            hd_q <= 1'b0;
        end else if (s2_valid_q) begin
            hd_q <= ~s2_t_q[SUM_WIDTH-1];
        end
    end

    assign hard_decision = hd_q;
`endif

    assign var_to_ch_0 = v2c_q[0];
    assign var_to_ch_1 = v2c_q[1];
    assign var_to_ch_2 = v2c_q[2];
    assign out_valid   = s3_valid_q;
    assign msg_cnt     = msg_cnt_q;

endmodule

// File: tb/tb_vnu_3.sv
module tb_vnu_3;

    logic       sys_clk = 1'b0;
    logic       rstn;
    logic       in_valid;
    logic [3:0] ch_msg, c0, c1, c2;
    logic [3:0] v0, v1, v2;
    logic       out_valid;
    logic [15:0] msg_cnt;
`ifdef VNU_DECISION_EN
    logic       hard_decision;
`endif

    vnu_3 dut (
        .sys_clk     (sys_clk),
        .rstn        (rstn),
        .in_valid    (in_valid),
        .ch_msg      (ch_msg),
        .ch_to_var_0 (c0),
        .ch_to_var_1 (c1),
        .ch_to_var_2 (c2),
        .var_to_ch_0 (v0),
        .var_to_ch_1 (v1),
        .var_to_ch_2 (v2),
        .out_valid   (out_valid),
        .msg_cnt     (msg_cnt)
`ifdef VNU_DECISION_EN
        ,
        .hard_decision (hard_decision)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [11:0] v;
        logic        hd;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          exp_cnt = 0;
    logic [11:0] last_v = '0;
    logic        last_hd = 1'b0;
    bit          mon_en = 1'b0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: index code <-> signed odd integer with plain arithmetic.
    function automatic int dec(input logic [3:0] code);
        int b;
        b = int'(code[2:0]);
        return code[3] ? (2 * b + 1) : -(2 * (7 - b) + 1);
    endfunction

    function automatic logic [3:0] enc(input int e);
        int a, mag;
        a   = (e < 0) ? -e : e;
        mag = (a - 1) / 4;
        if (mag > 7) mag = 7;
        return (e > 0) ? 4'(8 + mag) : 4'(7 - mag);
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic send(input logic [3:0] ch, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c);
        exp_t it;
        int   t;
        ch_msg = ch; c0 = a; c1 = b; c2 = c;
        in_valid = 1'b1;
        t = dec(ch) + dec(a) + dec(b) + dec(c);
        it.v   = {enc(t - dec(a)), enc(t - dec(b)), enc(t - dec(c))};
        it.hd  = (t >= 0);
        it.cyc = cyc + 3;
        sb.push_back(it);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            ch_msg = 4'($urandom); c0 = 4'($urandom); c1 = 4'($urandom); c2 = 4'($urandom);
            tick();
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            idle(1);
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 0);
        idle(2);
    endtask

    // Monitor: pops the scoreboard on every out_valid, checks hold otherwise.
    always @(negedge sys_clk) begin
        if (mon_en) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out_valid", 32'(out_valid), 0);
                end else begin
                    exp_t it;
                    it = sb.pop_front();
                    chk("latency", cyc, it.cyc);
                    chk("v2c", {20'd0, v0, v1, v2}, {20'd0, it.v});
`ifdef VNU_DECISION_EN
                    chk("hard_decision", 32'(hard_decision), 32'(it.hd));
`endif
                    last_v  = it.v;
                    last_hd = it.hd;
                    exp_cnt++;
                end
            end else begin
                chk("hold_v2c", {20'd0, v0, v1, v2}, {20'd0, last_v});
`ifdef VNU_DECISION_EN
                chk("hold_hd", 32'(hard_decision), 32'(last_hd));
`endif
            end
        end
    end

    task automatic check_reset_state(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_v2c"}, {20'd0, v0, v1, v2}, 0);
        chk({tag, "_msg_cnt"}, 32'(msg_cnt), 0);
`ifdef VNU_DECISION_EN
        chk({tag, "_hd"}, 32'(hard_decision), 0);
`endif
    endtask

    // Asynchronous reset mid-cycle; model discards everything in flight.
    task automatic do_reset();
        mon_en = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        check_reset_state("reset_async");
        sb.delete();
        last_v = '0; last_hd = 1'b0; exp_cnt = 0;
        in_valid = 1'b1;
        ch_msg = 4'hF; c0 = 4'hF; c1 = 4'hF; c2 = 4'hF;
        repeat (2) @(posedge sys_clk);
        #1;
        check_reset_state("reset_held");
        in_valid = 1'b0;
        #2;
        rstn = 1'b1;
        mon_en = 1'b1;
    endtask

    initial begin
        rstn = 1'b1; in_valid = 1'b0;
        ch_msg = '0; c0 = '0; c1 = '0; c2 = '0;
        #3;
        do_reset();
        // Reset was held with in_valid=1: nothing may emerge.
        idle(10);
        chk("post_reset_msg_cnt", 32'(msg_cnt), 0);

        // Directed cases.
        send(4'b1000, 4'b1000, 4'b1000, 4'b1000);
        idle(3);
        send(4'b1111, 4'b1111, 4'b1111, 4'b1111);
        idle(3);
        send(4'b1111, 4'b0000, 4'b1000, 4'b1000);
        idle(3);
        send(4'b0111, 4'b0111, 4'b0111, 4'b0111);
        drain();
        chk("msg_cnt_directed", 32'(msg_cnt), 32'(exp_cnt[15:0]));

        // Streaming: 4 back-to-back, a gap, one more.
        do_reset();
        idle(1);
        for (int i = 0; i < 4; i++) begin
            send(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
        end
        idle(1);
        send(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
        drain();
        chk("msg_cnt_stream", 32'(msg_cnt), 5);

        // Randomised traffic with random bubbles.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 7) begin
                send(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
            end else begin
                idle(1);
            end
        end
        drain();
        chk("msg_cnt_random", 32'(msg_cnt), 32'(exp_cnt[15:0]));

        // Reset one cycle after in_valid; nothing may emerge afterwards.
        send(4'b1111, 4'b1111, 4'b1000, 4'b0111);
        do_reset();
        for (int i = 0; i < 10; i++) begin
            chk("post_midreset_out_valid", 32'(out_valid), 0);
            idle(1);
        end
        chk("post_midreset_msg_cnt", 32'(msg_cnt), 0);

        // msg_cnt wrap: 65535 messages then one more.
        for (int i = 0; i < 65535; i++) begin
            send(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
        end
        drain();
        chk("msg_cnt_max", 32'(msg_cnt), 32'h0000_FFFF);
        send(4'b1000, 4'b1000, 4'b1000, 4'b1000);
        drain();
        chk("msg_cnt_wrap", 32'(msg_cnt), 0);

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
